// File: rtl/enigma_pkg.sv
// enigma_pkg: opcodes, controller state encoding and letter constants shared by controller and datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enigma_pkg;

    localparam int LETTERS  = 26;
    localparam int LETTER_W = 5;

    localparam logic [LETTER_W-1:0] LAST_LETTER = 5'd25;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD_L  = 3'd1;
    localparam logic [2:0] OP_LOAD_M  = 3'd2;
    localparam logic [2:0] OP_LOAD_R  = 3'd3;
    localparam logic [2:0] OP_ENCRYPT = 3'd4;
    localparam logic [2:0] OP_PLUG_A  = 3'd5;
    localparam logic [2:0] OP_PLUG_B  = 3'd6;
    localparam logic [2:0] OP_ZERO    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_LAUNCH = 2'd2,
        S_WAIT   = 2'd3
    } ctrl_state_t;

    // True when the value names a letter A..Z.
    function automatic logic is_letter(input logic [LETTER_W-1:0] v);
        return v <= LAST_LETTER;
    endfunction

endpackage

// File: rtl/enigma_pos_ctr.sv
// enigma_pos_ctr: mod-26 rotor position counter with load and single-step, plus notch detect.
// Latency: load/step visible the cycle after the edge that applies them.
// Backpressure: none; load has priority over step.
module enigma_pos_ctr
    import enigma_pkg::*;
#(
    parameter int NOTCH = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    input  logic                step,
    output logic [LETTER_W-1:0] pos,
    output logic                at_notch
);

    logic [LETTER_W-1:0] pos_q;
    logic [LETTER_W-1:0] pos_d;

    // Next position: load wins, otherwise advance with Z -> A wrap.
    always_comb begin
        pos_d = pos_q;
        if (load) begin
            pos_d = load_val;
        end else if (step) begin
            pos_d = (pos_q == LAST_LETTER) ? '0 : pos_q + 1'b1;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos      = pos_q;
    assign at_notch = (pos_q == LETTER_W'(NOTCH));

endmodule

// File: rtl/enigma_ctrl.sv
// enigma_ctrl: command sequencer owning rotor positions/stepping; ENIGMA_CTRL_DBLSTEP_EN enables double-step.
// Latency: non-ENCRYPT commands finish in 1 cycle; ENCRYPT gives out_valid >= 4 cycles after accept.
// Backpressure: in_ready low outside IDLE; commands presented while busy are dropped, never queued.
module enigma_ctrl
    import enigma_pkg::*;
#(
    parameter int NOTCH_R        = 21,
    parameter int NOTCH_M        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [2:0]          in_opcode,
    input  logic [LETTER_W-1:0] in_data,
    output logic                in_ready,
    output logic [LETTER_W-1:0] pos_l,
    output logic [LETTER_W-1:0] pos_m,
    output logic [LETTER_W-1:0] pos_r,
    output logic                plug_wr,
    output logic [LETTER_W-1:0] plug_a,
    output logic [LETTER_W-1:0] plug_b,
    output logic                dp_start,
    output logic [LETTER_W-1:0] dp_char_in,
    input  logic                dp_done,
    input  logic [LETTER_W-1:0] dp_char,
    output logic                out_valid,
    output logic [LETTER_W-1:0] out_char,
    output logic                err,
    output logic                busy
);

    // Last WAIT-cycle index before the timeout fires.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    ctrl_state_t         state_q;
    logic [7:0]          wait_cnt_q;
    logic [LETTER_W-1:0] letter_q;
    logic [LETTER_W-1:0] plug_a_q;
    logic [LETTER_W-1:0] plug_b_q;
    logic [LETTER_W-1:0] out_char_q;
    logic                a_pending_q;
    logic                plug_wr_q;
    logic                dp_start_q;
    logic                out_valid_q;
    logic                err_q;

    logic                accept;
    logic                needs_letter;
    logic                cmd_ok;
    logic                load_l_d, load_m_d, load_r_d;
    logic [LETTER_W-1:0] load_val_d;
    logic                step_l_d, step_m_d, step_r_d;
    logic                r_notch, m_notch, unused_l_notch;

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = ~in_ready;
    assign accept       = in_valid & in_ready;
    // NOP and ZERO ignore their data field; everything else needs a real letter.
    assign needs_letter = (in_opcode != OP_NOP) && (in_opcode != OP_ZERO);
    assign cmd_ok       = !needs_letter || is_letter(in_data);

    // Position loads from accepted LOAD_x / ZERO commands.
    always_comb begin
        load_l_d   = 1'b0;
        load_m_d   = 1'b0;
        load_r_d   = 1'b0;
        load_val_d = in_data;
        if (accept && cmd_ok) begin
            case (in_opcode)
                OP_LOAD_L: load_l_d = 1'b1;
                OP_LOAD_M: load_m_d = 1'b1;
                OP_LOAD_R: load_r_d = 1'b1;
                OP_ZERO: begin
                    load_l_d   = 1'b1;
                    load_m_d   = 1'b1;
                    load_r_d   = 1'b1;
                    load_val_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Rotor stepping in STEP, decided on pre-step positions.
    always_comb begin
        step_r_d = (state_q == S_STEP);
`ifdef ENIGMA_CTRL_DBLSTEP_EN
        // Historical anomaly: a middle rotor sitting on its notch drags itself and L along.
        step_m_d = step_r_d & (r_notch | m_notch);
        step_l_d = step_r_d & m_notch;
`else
        // Plain odometer: carries only ripple from right to left.
        step_m_d = step_r_d & r_notch;
        step_l_d = step_m_d & m_notch;
`endif
    end

    enigma_pos_ctr #(.NOTCH(0)) u_pos_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_l_d),
        .load_val (load_val_d),
        .step     (step_l_d),
        .pos      (pos_l),
        .at_notch (unused_l_notch)
    );

    enigma_pos_ctr #(.NOTCH(NOTCH_M)) u_pos_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_m_d),
        .load_val (load_val_d),
        .step     (step_m_d),
        .pos      (pos_m),
        .at_notch (m_notch)
    );

    enigma_pos_ctr #(.NOTCH(NOTCH_R)) u_pos_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_r_d),
        .load_val (load_val_d),
        .step     (step_r_d),
        .pos      (pos_r),
        .at_notch (r_notch)
    );

    // Sequencer FSM with registered strobes and held result/plug registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            letter_q    <= '0;
            plug_a_q    <= '0;
            plug_b_q    <= '0;
            out_char_q  <= '0;
            a_pending_q <= 1'b0;
            plug_wr_q   <= 1'b0;
            dp_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            plug_wr_q   <= 1'b0;
            dp_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!cmd_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            case (in_opcode)
                                OP_ENCRYPT: begin
                                    letter_q <= in_data;
                                    state_q  <= S_STEP;
                                end
                                OP_PLUG_A: begin
                                    plug_a_q    <= in_data;
                                    a_pending_q <= 1'b1;
                                end
                                OP_PLUG_B: begin
                                    if (a_pending_q) begin
                                        plug_b_q    <= in_data;
                                        plug_wr_q   <= 1'b1;
                                        a_pending_q <= 1'b0;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_STEP: begin
                    state_q    <= S_LAUNCH;
                    dp_start_q <= 1'b1;
                end
                S_LAUNCH: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    // A result in the final WAIT cycle still wins over the timeout.
                    if (dp_done) begin
                        out_char_q  <= dp_char;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (wait_cnt_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign plug_wr    = plug_wr_q;
    assign plug_a     = plug_a_q;
    assign plug_b     = plug_b_q;
    assign dp_start   = dp_start_q;
    assign dp_char_in = letter_q;
    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;
    assign err        = err_q;

endmodule

// File: tb/tb_enigma_ctrl.sv
// tb_enigma_ctrl: scoreboard bench for enigma_ctrl against a letter-arithmetic reference model.
// Latency: expected events carry the cycle they must appear in.
// Backpressure: driver waits on in_ready; stray strobes while busy must be dropped.
module tb_enigma_ctrl;

    localparam int NOTCH_R = 21;
    localparam int NOTCH_M = 4;
    localparam int TMO     = 15;

    localparam int K_START  = 0;
    localparam int K_RESULT = 1;
    localparam int K_ERR    = 2;
    localparam int K_PLUG   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_opcode;
    logic [4:0] in_data;
    logic       in_ready;
    logic [4:0] pos_l, pos_m, pos_r;
    logic       plug_wr;
    logic [4:0] plug_a, plug_b;
    logic       dp_start;
    logic [4:0] dp_char_in;
    logic       dp_done;
    logic [4:0] dp_char;
    logic       out_valid;
    logic [4:0] out_char;
    logic       err;
    logic       busy;

    enigma_ctrl #(
        .NOTCH_R        (NOTCH_R),
        .NOTCH_M        (NOTCH_M),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pos_l      (pos_l),
        .pos_m      (pos_m),
        .pos_r      (pos_r),
        .plug_wr    (plug_wr),
        .plug_a     (plug_a),
        .plug_b     (plug_b),
        .dp_start   (dp_start),
        .dp_char_in (dp_char_in),
        .dp_done    (dp_done),
        .dp_char    (dp_char),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int v0;
        int v1;
        int v2;
        int v3;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   resp_d  = 1;
    int   resp_ch = 0;

    // Reference model: rotor letters, pending plug letter, last result.
    int ml = 0, mm = 0, mr = 0, m_plug_a = 0, m_last = 0;
    bit m_pend = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int v0, input int v1, input int v2, input int v3);
        exp_t e;
        e = '{kind, c, v0, v1, v2, v3};
        sbq.push_back(e);
    endtask

    // One Enigma step of the model, judged on the letters before the step.
    task automatic advance_rotors();
        bit r_turn, m_turn, step_m, step_l;
        r_turn = (mr == NOTCH_R);
        m_turn = (mm == NOTCH_M);
`ifdef ENIGMA_CTRL_DBLSTEP_EN
        step_m = r_turn || m_turn;
        step_l = m_turn;
`else
        step_m = r_turn;
        step_l = r_turn && m_turn;
`endif
        mr = (mr + 1) % 26;
        if (step_m) mm = (mm + 1) % 26;
        if (step_l) ml = (ml + 1) % 26;
    endtask

    // Apply an accepted command to the model and queue what the DUT must show.
    task automatic model_cmd(input int op, input int data, input int d, input int ch, input int acc, input bit abort);
        if (op >= 1 && op <= 6 && data > 25) begin
            push(K_ERR, acc, m_last, ml, mm, mr);
            return;
        end
        case (op)
            1: ml = data;
            2: mm = data;
            3: mr = data;
            7: begin ml = 0; mm = 0; mr = 0; end
            5: begin m_plug_a = data; m_pend = 1'b1; end
            6: begin
                if (m_pend) begin
                    push(K_PLUG, acc, m_plug_a, data, 0, 0);
                    m_pend = 1'b0;
                end else begin
                    push(K_ERR, acc, m_last, ml, mm, mr);
                end
            end
            4: begin
                advance_rotors();
                push(K_START, acc + 1, data, ml, mm, mr);
                if (!abort) begin
                    if (d >= 1 && d <= TMO) begin
                        m_last = ch;
                        push(K_RESULT, acc + 2 + d, ch, ml, mm, mr);
                    end else begin
                        push(K_ERR, acc + 2 + TMO, m_last, ml, mm, mr);
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Present one command when ready; d = WAIT cycle of dp_done (0 = never).
    task automatic send(input int op, input int data, input int d, input int ch,
                        input bit junk, input bit abort, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (in_ready !== 1'b1) begin
            chk("ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        resp_d    = d;
        resp_ch   = ch;
        in_opcode = 3'(op);
        in_data   = 5'(data);
        in_valid  = 1'b1;
        model_cmd(op, data, d, ch, acc, abort);
        @(negedge clk);
        in_valid = 1'b0;
        if (junk && op == 4 && data <= 25) begin
            in_opcode = 3'($urandom_range(0, 7));
            in_data   = 5'($urandom_range(0, 31));
            in_valid  = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic cmd(input int op, input int data);
        int acc;
        send(op, data, 1, 0, 1'b0, 1'b0, acc);
    endtask

    task automatic enc(input int data, input int d, input int ch, input bit junk);
        int acc;
        send(4, data, d, ch, junk, 1'b0, acc);
    endtask

    task automatic check_pos(input string nm);
        chk({nm, "_l"}, 32'(pos_l), ml);
        chk({nm, "_m"}, 32'(pos_m), mm);
        chk({nm, "_r"}, 32'(pos_r), mr);
    endtask

    initial begin
        int acc, op, data, d, r, ch, n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 3'd0;
        in_data   = 5'd0;
        dp_done   = 1'b0;
        dp_char   = 5'd0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (mon_en) begin
                        chk("busy_vs_ready", 32'(busy), 32'(!in_ready));
                        if (dp_start || out_valid || err || plug_wr) begin
                            if (sbq.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_event: start=%0b valid=%0b err=%0b plug_wr=%0b cycle %0d, expected no event",
                                         dp_start, out_valid, err, plug_wr, cyc);
                            end else begin
                                e = sbq.pop_front();
                                chk("event_kind", 32'({dp_start, out_valid, err, plug_wr}), 32'(4'b1000 >> e.kind));
                                chk("event_cycle", cyc, e.cyc);
                                case (e.kind)
                                    K_START: begin
                                        chk("dp_char_in", 32'(dp_char_in), e.v0);
                                        chk("start_pos_l", 32'(pos_l), e.v1);
                                        chk("start_pos_m", 32'(pos_m), e.v2);
                                        chk("start_pos_r", 32'(pos_r), e.v3);
                                    end
                                    K_PLUG: begin
                                        chk("plug_a", 32'(plug_a), e.v0);
                                        chk("plug_b", 32'(plug_b), e.v1);
                                    end
                                    default: begin
                                        chk("ev_out_char", 32'(out_char), e.v0);
                                        chk("ev_in_ready", 32'(in_ready), 32'd1);
                                        chk("ev_pos_l", 32'(pos_l), e.v1);
                                        chk("ev_pos_m", 32'(pos_m), e.v2);
                                        chk("ev_pos_r", 32'(pos_r), e.v3);
                                    end
                                endcase
                            end
                        end
                    end
                end
            end
            begin : responder
                int rd, rc;
                forever begin
                    @(negedge clk);
                    if (dp_start === 1'b1) begin
                        rd = resp_d;
                        rc = resp_ch;
                        if (rd > 0) begin
                            repeat (rd) @(negedge clk);
                            dp_done = 1'b1;
                            dp_char = 5'(rc);
                            @(negedge clk);
                            dp_done = 1'b0;
                            dp_char = 5'($urandom_range(0, 25));
                        end
                    end
                end
            end
        join_none

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        check_pos("rst_pos");
        chk("rst_plug_wr", 32'(plug_wr), 32'd0);
        chk("rst_plug_a", 32'(plug_a), 32'd0);
        chk("rst_plug_b", 32'(plug_b), 32'd0);
        chk("rst_dp_start", 32'(dp_start), 32'd0);
        chk("rst_dp_char_in", 32'(dp_char_in), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_char", 32'(out_char), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ADU then three encryptions: ADV, AEW, then BFX or AEX.
        cmd(1, 0);
        cmd(2, 3);
        cmd(3, 20);
        check_pos("load_pos");
        enc(7, 1, 19, 1'b0);
        enc(8, 1, 2, 1'b1);
        enc(9, 1, 24, 1'b0);

        // R wraps Z -> A, M untouched.
        cmd(3, 25);
        enc(0, 1, 5, 1'b0);

        // Plugboard pairs, self-pair, orphan PLUG_B.
        cmd(5, 1);
        cmd(6, 7);
        cmd(6, 9);
        cmd(5, 4);
        cmd(6, 4);

        // Illegal letters are dropped with err.
        enc(30, 1, 0, 1'b0);
        cmd(2, 26);

        // Timeout, late-but-legal results, and one cycle too late.
        enc(3, 0, 0, 1'b0);
        enc(4, 5, 11, 1'b1);
        enc(5, 15, 17, 1'b0);
        enc(6, 16, 13, 1'b0);
        cmd(7, 31);
        check_pos("zero_pos");

        // Reset during WAIT aborts; the late dp_done must be ignored.
        cmd(3, 9);
        send(4, 7, 8, 3, 1'b1, 1'b1, acc);
        while (cyc < acc + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ml = 0; mm = 0; mr = 0; m_last = 0; m_pend = 1'b0; m_plug_a = 0;
        check_pos("abort_pos");
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_char", 32'(out_char), 32'd0);
        repeat (20) @(negedge clk);

        // Randomised command stream.
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if (op > 7) op = 4;
            data = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            r = $urandom_range(0, 19);
            d = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 15 : 1 + (r % 4);
            ch = $urandom_range(0, 25);
            send(op, data, d, ch, 1'($urandom_range(0, 1)), 1'b0, acc);
        end

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
